// File: rtl/mem_access_ctrl_pkg.sv
// Shared address map, status-word bit positions and FSM encoding for the MEM-stage
// access unit and anything that talks to it.
package mem_access_ctrl_pkg;

    localparam logic [31:0] ADDR_SERIAL_PORT       = 32'h0000_BF00;
    localparam logic [31:0] ADDR_SERIAL_PORT_STATE = 32'h0000_BF01;
    localparam logic [31:0] ADDR_KEYBOARD          = 32'h0000_BF02;

    localparam int ST_TX_READY     = 0;
    localparam int ST_DATA_READY   = 1;
    localparam int ST_KBD_NONEMPTY = 2;
    localparam int ST_KBD_OVF      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_RD,
        S_RAM_WR,
        S_WR_HOLD,
        S_UART_RD,
        S_UART_WAIT_TX,
        S_UART_WR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_SERIAL,
        DEC_STATE,
        DEC_KEYBOARD
    } addr_dec_t;

    function automatic addr_dec_t decode_addr(input logic [31:0] addr);
        if (addr == ADDR_SERIAL_PORT)       return DEC_SERIAL;
        if (addr == ADDR_SERIAL_PORT_STATE) return DEC_STATE;
        if (addr == ADDR_KEYBOARD)          return DEC_KEYBOARD;
        return DEC_RAM;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_kbd_fifo.sv
// Synchronous FIFO buffering PS/2 scan codes between CPU polls; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module mem_access_ctrl_kbd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle MEM-stage access unit: one load/store at a time over valid/ready,
// sequencing SRAM wait states, UART strobes and memory-mapped status/keyboard reads.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int RAM_WAIT   = 1,
    parameter int UART_PULSE = 2,
    parameter int KBD_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          ram_en,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          uart_wrn,
    output logic          uart_rdn,
    input  logic          uart_data_ready,
    input  logic          uart_tx_ready,
    input  logic [7:0]    ps2_scan_code,
    input  logic          ps2_data_ready
);
    localparam int CMAX = ((RAM_WAIT + 1) > UART_PULSE) ? (RAM_WAIT + 1) : UART_PULSE;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] w_rdata_nxt;
    logic          w_load_rdata;
    logic          r_ovf;
    logic          r_ps2_d;
    logic          w_bus_oe;
    logic [DW-1:0] w_bus_val;
    logic [DW-1:0] w_status;
    addr_dec_t     w_dec;
    logic          w_accept;
    logic          w_pop;
    logic          w_stat_rd;
    logic          w_push_req;
    logic          w_ovf_set;
    logic [7:0]    w_kbd_dout;
    logic          w_kbd_empty;
    logic          w_kbd_full;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_dec      = decode_addr(32'(req_addr));
    assign ram_addr   = r_ram_addr;
    assign resp_rdata = r_rdata;
    assign ram_data   = w_bus_oe ? w_bus_val : 'z;

    // A push into a full FIFO survives only if the same edge pops the head.
    assign w_push_req = ps2_data_ready && !r_ps2_d;
    assign w_ovf_set  = w_push_req && w_kbd_full && !w_pop;

    always_comb begin
        w_status                  = '0;
        w_status[ST_TX_READY]     = uart_tx_ready;
        w_status[ST_DATA_READY]   = uart_data_ready;
        w_status[ST_KBD_NONEMPTY] = !w_kbd_empty;
        w_status[ST_KBD_OVF]      = r_ovf;
    end

    mem_access_ctrl_kbd_fifo #(
        .WIDTH (8),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (ps2_scan_code),
        .dout  (w_kbd_dout),
        .empty (w_kbd_empty),
        .full  (w_kbd_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_ps2_d <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_ps2_d <= ps2_data_ready;
            r_ovf   <= w_ovf_set || (r_ovf && !w_stat_rd);
            if (w_load_rdata) r_rdata <= w_rdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ram_addr <= req_addr;
            r_wdata    <= req_wdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_nxt    = '0;
        w_load_rdata = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_pop        = 1'b0;
        w_stat_rd    = 1'b0;
        w_bus_oe     = 1'b0;
        w_bus_val    = r_wdata;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        ram_en       = 1'b0;
        ram_oe       = 1'b1;
        ram_we       = 1'b1;
        uart_wrn     = 1'b1;
        uart_rdn     = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    unique case (w_dec)
                        DEC_SERIAL: begin
                            if (req_we) begin
                                w_next = S_UART_WAIT_TX;
                            end else if (uart_data_ready) begin
                                w_next = S_UART_RD;
                            end else begin
                                w_next       = S_DONE;
                                w_load_rdata = 1'b1;
                                w_rdata_nxt  = '0;
                            end
                        end
                        DEC_STATE: begin
                            w_next = S_DONE;
                            if (!req_we) begin
                                w_load_rdata = 1'b1;
                                w_rdata_nxt  = w_status;
                                w_stat_rd    = 1'b1;
                            end
                        end
                        DEC_KEYBOARD: begin
                            w_next = S_DONE;
                            if (!req_we) begin
                                w_load_rdata = 1'b1;
                                w_rdata_nxt  = w_kbd_empty ? '0 : DW'(w_kbd_dout);
                                w_pop        = !w_kbd_empty;
                            end
                        end
                        default: w_next = req_we ? S_RAM_WR : S_RAM_RD;
                    endcase
                end
            end
            S_RAM_RD: begin
                ram_oe = 1'b0;
                if (r_cnt == CW'(RAM_WAIT)) begin
                    w_next       = S_DONE;
                    w_load_rdata = 1'b1;
                    w_rdata_nxt  = ram_data;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RAM_WR: begin
                ram_we   = 1'b0;
                w_bus_oe = 1'b1;
                if (r_cnt == CW'(RAM_WAIT)) w_next = S_WR_HOLD;
                else                        w_cnt_nxt = r_cnt + 1'b1;
            end
            S_WR_HOLD: begin
                // Data held one cycle past the we rising edge for SRAM hold time.
                w_bus_oe = 1'b1;
                w_next   = S_DONE;
            end
            S_UART_RD: begin
                ram_en   = 1'b1;
                uart_rdn = 1'b0;
                if (r_cnt == CW'(UART_PULSE - 1)) begin
                    w_next       = S_DONE;
                    w_load_rdata = 1'b1;
                    w_rdata_nxt  = DW'(ram_data[7:0]);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_UART_WAIT_TX: begin
                ram_en = 1'b1;
                if (uart_tx_ready) w_next = S_UART_WR;
            end
            S_UART_WR: begin
                ram_en    = 1'b1;
                uart_wrn  = 1'b0;
                w_bus_oe  = 1'b1;
                w_bus_val = DW'(r_wdata[7:0]);
                if (r_cnt == CW'(UART_PULSE - 1)) w_next = S_DONE;
                else                              w_cnt_nxt = r_cnt + 1'b1;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
